// File: rtl/serdes_128to32_tx.sv
// ============================================================================
// Module   : serdes_128to32_tx
// Purpose  : 128-bit to 32-bit width-down serializer, LSB beat first, with
//            zero-bubble word chaining and per-beat downstream backpressure.
//            Optional end-of-word flag port: define SERDES_LAST_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serdes_128to32_tx (
    input  logic         CLK,
    input  logic         nRST,
    output logic         in_deq__ENA,
    input  logic         in_deq__RDY,
    input  logic [127:0] in_first,
    output logic         out_enq__ENA,
    output logic [31:0]  out_enq_v,
`ifdef SERDES_LAST_FLAG_EN
    output logic         out_enq_last,
`endif
    input  logic         out_enq__RDY
);

    localparam logic [1:0] C_LAST_BEAT = 2'd3;

    logic [127:0] hold;
    logic         busy;
    logic [1:0]   beat;

    logic         accept;
    logic         take;
    logic         load;

    always_comb begin
        accept = busy & out_enq__RDY;
        // A new word may enter only when the slot is empty or its final beat leaves now.
        take   = ~busy | ((beat == C_LAST_BEAT) & out_enq__RDY);
        load   = nRST & in_deq__RDY & take;
    end

    assign in_deq__ENA  = load;
    assign out_enq__ENA = accept;
    assign out_enq_v    = busy ? hold[31:0] : 32'd0;

`ifdef SERDES_LAST_FLAG_EN
    assign out_enq_last = busy & (beat == C_LAST_BEAT);
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hold <= 128'd0;
            busy <= 1'b0;
            beat <= 2'd0;
        end else if (load) begin
            // Load wins over a coincident beat-3 accept, keeping the stream gap-free.
            hold <= in_first;
            busy <= 1'b1;
            beat <= 2'd0;
        end else if (accept) begin
            hold <= {32'd0, hold[127:32]};
            beat <= beat + 2'd1;
            if (beat == C_LAST_BEAT) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
